// File: rtl/panel_input_cond_pkg.sv
// Shared constants and types for the panel input conditioner and the pattern generator.
// Holds the pattern encodings, the scale and index limits, and the debounce default.
package panel_input_cond_pkg;

  typedef enum logic [2:0] {
    PATTN_NONE = 3'b000,
    PATTN_BARS = 3'b001,
    PATTN_TRI  = 3'b010,
    PATTN_CIRC = 3'b100
  } pattn_e;

  localparam int unsigned DEB_LIMIT_DEF = 32'h000F_FFFE;
  localparam int unsigned IDX_MAX_DEF   = 7;
  localparam int unsigned SCAL_MIN_DEF  = 1;
  localparam int unsigned SCAL_MAX_DEF  = 5;

  // Lane numbering for the synchronizer-only and debounced input groups.
  localparam int NUM_SYNC  = 3;
  localparam int SYNC_A    = 0;
  localparam int SYNC_B    = 1;
  localparam int SYNC_UP   = 2;

  localparam int NUM_DEB   = 4;
  localparam int LANE_DWN  = 0;
  localparam int LANE_BTN0 = 1;
  localparam int LANE_BTN1 = 2;
  localparam int LANE_BTN2 = 3;

  typedef struct packed {
    logic [3:0] indx;
    logic       rsvd;
    logic [2:0] scal;
  } led_t;

  // acc = {btn2, btn1, btn0}; the lowest-numbered button wins a same-cycle tie.
  function automatic pattn_e btn_pattn(input logic [2:0] acc, input pattn_e cur);
    pattn_e nxt;
    nxt = cur;
    if (acc[0])      nxt = PATTN_BARS;
    else if (acc[1]) nxt = PATTN_TRI;
    else if (acc[2]) nxt = PATTN_CIRC;
    return nxt;
  endfunction

endpackage

// File: rtl/panel_input_cond_if.sv
// Raw panel pins in, conditioned control state out.
interface panel_input_cond_if;
  logic       rot_A;
  logic       rot_B;
  logic       rot_dwn;
  logic       BTN0;
  logic       BTN1;
  logic       BTN2;
  logic       scal_up;
  logic [2:0] pattn;
  logic [2:0] pattn_scal;
  logic [3:0] rot_indx;
  logic       rot_step;
  logic       rot_dir;
  logic       press;
  logic [7:0] led;

  modport slave (
    input  rot_A, rot_B, rot_dwn, BTN0, BTN1, BTN2, scal_up,
    output pattn, pattn_scal, rot_indx, rot_step, rot_dir, press, led
  );

  modport master (
    output rot_A, rot_B, rot_dwn, BTN0, BTN1, BTN2, scal_up,
    input  pattn, pattn_scal, rot_indx, rot_step, rot_dir, press, led
  );
endinterface

// File: rtl/panel_input_cond_input_debounce.sv
// One input lane: 2-flop synchronizer, optionally followed by a saturating
// hold counter that fires a single accept pulse when the hold reaches DEB_LIMIT.
module input_debounce
  import panel_input_cond_pkg::*;
#(
  parameter int          DEB_W     = 20,
  parameter int unsigned DEB_LIMIT = DEB_LIMIT_DEF,
  parameter bit          SYNC_ONLY = 1'b0,
  parameter bit          RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic accept
);
  localparam logic [DEB_W-1:0] LIM = DEB_W'(DEB_LIMIT);
  localparam logic [DEB_W-1:0] ONE = DEB_W'(1);

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] cnt;
  logic             acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], din};
  end

  assign sync = sync_q[1];

  // Sync-only lanes pin the counter at zero so it folds away entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      acc_q <= 1'b0;
    end else if (SYNC_ONLY) begin
      cnt   <= '0;
      acc_q <= 1'b0;
    end else begin
      acc_q <= sync_q[1] && (cnt == LIM - ONE);
      if (!sync_q[1])     cnt <= '0;
      else if (cnt < LIM) cnt <= cnt + ONE;
    end
  end

  assign accept = acc_q;

endmodule

// File: rtl/panel_input_cond.sv
// Panel input conditioner: synchronizes encoder pins, filters quadrature into
// detents, debounces push/buttons and holds pattern, scale and rotation state.
module panel_input_cond
  import panel_input_cond_pkg::*;
#(
  parameter int          DEB_W     = 20,
  parameter int unsigned DEB_LIMIT = DEB_LIMIT_DEF,
  parameter int unsigned IDX_MAX   = IDX_MAX_DEF,
  parameter int unsigned SCAL_MIN  = SCAL_MIN_DEF,
  parameter int unsigned SCAL_MAX  = SCAL_MAX_DEF
) (
  input logic               clk,
  input logic               reset,
  panel_input_cond_if.slave pif
);
  localparam logic [3:0] IDX_TOP = 4'(IDX_MAX);
  localparam logic [2:0] SCAL_LO = 3'(SCAL_MIN);
  localparam logic [2:0] SCAL_HI = 3'(SCAL_MAX);

  logic [NUM_SYNC-1:0] sync_raw, sync_lvl, sync_acc_unused;
  logic [NUM_DEB-1:0]  deb_raw, deb_acc, deb_lvl_unused;

  assign sync_raw[SYNC_A]   = pif.rot_A;
  assign sync_raw[SYNC_B]   = pif.rot_B;
  assign sync_raw[SYNC_UP]  = pif.scal_up;
  assign deb_raw[LANE_DWN]  = pif.rot_dwn;
  assign deb_raw[LANE_BTN0] = pif.BTN0;
  assign deb_raw[LANE_BTN1] = pif.BTN1;
  assign deb_raw[LANE_BTN2] = pif.BTN2;

  // Encoder channels idle high, so their synchronizers come out of reset at 1.
  for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
    input_debounce #(
      .DEB_W(DEB_W), .DEB_LIMIT(DEB_LIMIT), .SYNC_ONLY(1'b1), .RST_VAL(i != SYNC_UP)
    ) u_lane (
      .clk(clk), .reset(reset), .din(sync_raw[i]),
      .sync(sync_lvl[i]), .accept(sync_acc_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_DEB; i++) begin : g_deb
    input_debounce #(
      .DEB_W(DEB_W), .DEB_LIMIT(DEB_LIMIT), .SYNC_ONLY(1'b0), .RST_VAL(1'b0)
    ) u_lane (
      .clk(clk), .reset(reset), .din(deb_raw[i]),
      .sync(deb_lvl_unused[i]), .accept(deb_acc[i])
    );
  end

  logic a_s, b_s, up_s;
  assign a_s  = sync_lvl[SYNC_A];
  assign b_s  = sync_lvl[SYNC_B];
  assign up_s = sync_lvl[SYNC_UP];

  // q1 tracks the last full-agreement state (11/00), q2 the last split state (01/10);
  // chatter inside one state class cannot move either flag.
  logic q1, q2, q1_d, detent;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1   <= 1'b1;
      q2   <= 1'b1;
      q1_d <= 1'b1;
    end else begin
      q1_d <= q1;
      if (a_s && b_s)        q1 <= 1'b1;
      else if (!a_s && !b_s) q1 <= 1'b0;
      if (!a_s && b_s)       q2 <= 1'b1;
      else if (a_s && !b_s)  q2 <= 1'b0;
    end
  end

  assign detent = q1 & ~q1_d;

  logic [3:0] indx_q;
  logic       step_q, dir_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      indx_q <= 4'd0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      step_q <= detent;
      if (detent) begin
        dir_q <= q2;
        if (q2) indx_q <= (indx_q == 4'd0) ? IDX_TOP : indx_q - 4'd1;
        else    indx_q <= (indx_q == IDX_TOP) ? 4'd0 : indx_q + 4'd1;
      end
    end
  end

  logic [2:0] scal_q;
  logic       press_q;
  pattn_e     pattn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scal_q  <= 3'd0;
      press_q <= 1'b0;
      pattn_q <= PATTN_NONE;
    end else begin
      press_q <= deb_acc[LANE_DWN];
      // A decrement from 0 is blocked by the SCAL_LO floor, so 0 sticks.
      if (deb_acc[LANE_DWN]) begin
        if (up_s) begin
          if (scal_q < SCAL_HI) scal_q <= scal_q + 3'd1;
        end else if (scal_q > SCAL_LO) begin
          scal_q <= scal_q - 3'd1;
        end
      end
      pattn_q <= btn_pattn(deb_acc[LANE_BTN2:LANE_BTN0], pattn_q);
    end
  end

  led_t led_w;
  assign led_w = '{indx: indx_q, rsvd: 1'b0, scal: scal_q};

  assign pif.pattn      = pattn_q;
  assign pif.pattn_scal = scal_q;
  assign pif.rot_indx   = indx_q;
  assign pif.rot_step   = step_q;
  assign pif.rot_dir    = dir_q;
  assign pif.press      = press_q;
  assign pif.led        = led_w;

endmodule
